// File: rtl/seq1001_frame_tx_if.sv
// rtl/seq1001_frame_tx_if.sv - frame request handshake bundle for seq1001_frame_tx
//
// Purpose: carries one payload word from a requester to the frame transmitter
// on a valid/ready handshake.
// Signals:
//   data_in  payload word, sampled by the transmitter only on accept
//   valid    requester holds a frame request
//   ready    transmitter can accept a frame this cycle
// Modports: master = requester side, slave = transmitter side.
interface seq1001_frame_tx_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/seq1001_frame_tx.sv
// rtl/seq1001_frame_tx.sv - serial frame transmitter: sync 1001, payload MSB-first, idle zeros
//
// Purpose: accepts a payload word on req_if and shifts out one frame on dout_o:
// the sync pattern 1001, the payload MSB-first, then GAP idle zeros. One IDLE
// cycle always separates frames.
// Ports:
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset
//   req_if        slave side of the request handshake (data_in, valid, ready)
//   dout_o        registered serial line
//   busy_o        high while a frame is in SYNC, DATA or GAP
//   frame_done_o  one-cycle pulse in the first GAP cycle
module seq1001_frame_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  seq1001_frame_tx_if.slave  req_if,
  output logic               dout_o,
  output logic               busy_o,
  output logic               frame_done_o
);

  // Counter must reach the longest phase's terminal count: max(4, DATA_W, GAP)-1.
  localparam int CNT_MAX = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W - 1 : 3)
                                          : ((GAP > 4) ? GAP - 1 : 3);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP_ST = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              dout_q, dout_d;
  logic              fd_q, fd_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dout_d  = 1'b0;
    fd_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // ready is high in IDLE, so valid alone means accept.
        if (req_if.valid) begin
          state_d = SYNC;
          cnt_d   = '0;
          sh_d    = req_if.data_in;
        end
      end
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = GAP_ST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          sh_d  = sh_q << 1;
        end
      end
      GAP_ST: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Next line value is derived from where we are going, so dout_o is a pure
    // flop output that lines up with state_q in the following cycle.
    case (state_d)
      SYNC:    dout_d = (cnt_d == '0) || (cnt_d == SYNC_LAST);
      DATA:    dout_d = sh_d[DATA_W-1];
      default: dout_d = 1'b0;
    endcase

    fd_d = (state_q == DATA) && (state_d == GAP_ST);
  end

  assign req_if.ready = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign dout_o       = dout_q;
  assign frame_done_o = fd_q;

endmodule
